// File: rtl/aes_pkg.sv
// Shared types, constants and helpers for the serial AES SubBytes stage.
// ShiftRows here is pure byte wiring.
package aes_pkg;

  localparam int AES_NB_BYTES = 16;

  typedef logic [127:0] aes_state_t;
  typedef logic [7:0]   aes_byte_t;

  typedef enum logic [1:0] {
    SB_IDLE,
    SB_BUSY,
    SB_DONE
  } sb_state_e;

  // Row r of the output takes the input row rotated left by r columns.
  function automatic aes_state_t shift_rows(aes_state_t s);
    aes_state_t o;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        o[127-8*(r+4*c) -: 8] =
          s[127-8*(r+4*((c+r)%4)) -: 8];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/BoyarSbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
// Shared by every AES datapath stage that needs byte substitution.
module BoyarSbox (
  input  logic [7:0] U,
  output logic [7:0] S
);

  localparam logic [2047:0] TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign S = TBL[2047-8*int'(U) -: 8];

endmodule

// File: rtl/aes_subbytes_serial.sv
// Serial AES SubBytes: LANES S-boxes sweep the 16 state bytes over 16/LANES beats.
// Define AES_SUBBYTES_SHIFTROWS_EN to fold ShiftRows into the output wiring.
module aes_subbytes_serial
  import aes_pkg::*;
#(
  parameter int LANES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  aes_state_t in_state,
  output logic       out_valid,
  input  logic       out_ready,
  output aes_state_t out_state,
  output logic       busy
);

  localparam int N  = AES_NB_BYTES / LANES;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 ||
        LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("aes_subbytes_serial: illegal LANES");
  end

  sb_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  aes_state_t src_q, src_d;
  aes_state_t res_q, res_d;
  logic       out_valid_q, busy_q;

  aes_byte_t sb_in  [LANES];
  aes_byte_t sb_out [LANES];

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    BoyarSbox u_sbox (
      .U (sb_in[j]),
      .S (sb_out[j])
    );
  end

  assign in_ready = (state_q == SB_IDLE) |
                    ((state_q == SB_DONE) & out_ready);

  always_comb begin
    int base;
    base = (N > 1) ? int'(cnt_q) * LANES : 0;
    for (int j = 0; j < LANES; j++) begin
      sb_in[j] = src_q[127-8*(base+j) -: 8];
    end
  end

  always_comb begin
    int base;
    state_d = state_q;
    cnt_d   = cnt_q;
    src_d   = src_q;
    res_d   = res_q;
    base    = (N > 1) ? int'(cnt_q) * LANES : 0;
    unique case (state_q)
      SB_IDLE: begin
        if (in_valid) begin
          src_d   = in_state;
          cnt_d   = '0;
          state_d = SB_BUSY;
        end
      end
      SB_BUSY: begin
        for (int j = 0; j < LANES; j++) begin
          res_d[127-8*(base+j) -: 8] = sb_out[j];
        end
        if (N == 1 || cnt_q == CW'(N-1)) begin
          state_d = SB_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SB_DONE: begin
        if (out_ready) begin
          if (in_valid) begin
            src_d   = in_state;
            cnt_d   = '0;
            state_d = SB_BUSY;
          end else begin
            state_d = SB_IDLE;
          end
        end
      end
      default: state_d = SB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SB_IDLE;
      cnt_q       <= '0;
      src_q       <= '0;
      res_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      src_q       <= src_d;
      res_q       <= res_d;
      out_valid_q <= (state_d == SB_DONE);
      busy_q      <= (state_d == SB_BUSY);
    end
  end

  assign out_valid = out_valid_q;
  assign busy      = busy_q;

`ifdef AES_SUBBYTES_SHIFTROWS_EN
  assign out_state = shift_rows(res_q);
`else
  assign out_state = res_q;
`endif

endmodule

// File: tb/tb_aes_subbytes_serial.sv
// Directed bench for aes_subbytes_serial at LANES = 1, 4 and 16.
// Expected S-box results are hand-taken from the FIPS-197 tables.
module tb_aes_subbytes_serial;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         iv   [3];
  logic         ir   [3];
  logic [127:0] is_  [3];
  logic         ov   [3];
  logic         ordy [3];
  logic [127:0] os   [3];
  logic         bsy  [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gd
    aes_subbytes_serial #(.LANES(1 << (2*g))) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (iv[g]),
      .in_ready  (ir[g]),
      .in_state  (is_[g]),
      .out_valid (ov[g]),
      .out_ready (ordy[g]),
      .out_state (os[g]),
      .busy      (bsy[g])
    );
  end

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] sr(input logic [127:0] s);
    logic [127:0] o;
`ifdef AES_SUBBYTES_SHIFTROWS_EN
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] =
          s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
`else
    o = s;
`endif
    return o;
  endfunction

  function automatic logic [127:0] fill(input logic [7:0] b);
    return {16{b}};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input int d, input logic [127:0] st);
    int n;
    n = 0;
    while (!ir[d] && n < 40) begin
      step();
      n++;
    end
    if (!ir[d]) chk("accept_timeout", 128'(ir[d]), 128'd1);
    iv[d]  = 1'b1;
    is_[d] = st;
    step();
    iv[d]  = 1'b0;
  endtask

  task automatic wait_out(input int d, input int lat,
                          input logic [127:0] exp,
                          input string tag);
    int n;
    n = 0;
    while (!ov[d] && n < 40) begin
      step();
      n++;
    end
    chk({tag, "_lat"}, 128'(n), 128'(lat));
    chk({tag, "_data"}, os[d], sr(exp));
  endtask

  task automatic release_out(input int d);
    ordy[d] = 1'b1;
    step();
    ordy[d] = 1'b0;
    chk("release_ov", 128'(ov[d]), 128'd0);
  endtask

  localparam logic [127:0] FIPS_IN  =
    128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] FIPS_OUT =
    128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] ONE_IN   =
    128'h0053ff01000000000000000000000000;
  localparam logic [127:0] ONE_OUT  =
    128'h63ed167c636363636363636363636363;
  localparam logic [127:0] INC_IN   =
    128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] INC_OUT  =
    128'h637c777bf26b6fc53001672bfed7ab76;

  logic [127:0] s_in  [8];
  logic [127:0] s_out [8];

  initial begin
    int i_in, i_out, last, cyc;
    logic acc;
    for (int d = 0; d < 3; d++) begin
      iv[d] = 1'b0; ordy[d] = 1'b0; is_[d] = '0;
    end
    #12;
    for (int d = 0; d < 3; d++) begin
      chk("rst_ov", 128'(ov[d]), 128'd0);
      chk("rst_ir", 128'(ir[d]), 128'd1);
      chk("rst_os", os[d], 128'd0);
    end
    chk("rst_busy", 128'(bsy[0]), 128'd0);
    rst = 1'b0;
    step();

    accept(0, ONE_IN);
    wait_out(0, 16, ONE_OUT, "single");
    release_out(0);

    for (int d = 0; d < 3; d++) begin
      accept(d, FIPS_IN);
      wait_out(d, (d == 0) ? 16 : (d == 1) ? 4 : 1,
               FIPS_OUT, "fips");
      release_out(d);
    end
`ifdef AES_SUBBYTES_SHIFTROWS_EN
    chk("fips_sr_lit", sr(FIPS_OUT),
        128'hd4bf5d30e0b452aeb84111f11e2798e5);
`endif

    accept(0, fill(8'h11));
    wait_out(0, 16, fill(8'h82), "bp_first");
    for (int k = 0; k < 10; k++) begin
      step();
      chk("bp_ov", 128'(ov[0]), 128'd1);
      chk("bp_os", os[0], sr(fill(8'h82)));
      chk("bp_ir", 128'(ir[0]), 128'd0);
      chk("bp_busy", 128'(bsy[0]), 128'd0);
    end
    ordy[0] = 1'b1;
    iv[0]   = 1'b1;
    is_[0]  = fill(8'h22);
    #1;
    chk("bp_ir_comb", 128'(ir[0]), 128'd1);
    step();
    ordy[0] = 1'b0;
    iv[0]   = 1'b0;
    chk("bp_busy_next", 128'(bsy[0]), 128'd1);
    wait_out(0, 16, fill(8'h93), "bp_second");
    release_out(0);

    accept(0, FIPS_IN);
    for (int k = 0; k < 8; k++) begin
      iv[0]  = k[0];
      is_[0] = fill(8'(k));
      #1;
      chk("stall_ir", 128'(ir[0]), 128'd0);
      step();
      chk("stall_src", gd[0].u_dut.src_q, FIPS_IN);
    end
    iv[0] = 1'b0;
    wait_out(0, 8, FIPS_OUT, "stall");
    release_out(0);

    s_in[0] = FIPS_IN;      s_out[0] = FIPS_OUT;
    s_in[1] = ONE_IN;       s_out[1] = ONE_OUT;
    s_in[2] = INC_IN;       s_out[2] = INC_OUT;
    s_in[3] = fill(8'h11);  s_out[3] = fill(8'h82);
    s_in[4] = fill(8'h22);  s_out[4] = fill(8'h93);
    s_in[5] = fill(8'h33);  s_out[5] = fill(8'hc3);
    s_in[6] = fill(8'haa);  s_out[6] = fill(8'hac);
    s_in[7] = fill(8'h55);  s_out[7] = fill(8'hfc);
    i_in = 0; i_out = 0; last = 0; cyc = 0;
    ordy[0] = 1'b1;
    iv[0]   = 1'b1;
    is_[0]  = s_in[0];
    while (i_out < 8 && cyc < 300) begin
      acc = iv[0] & ir[0];
      step();
      cyc++;
      if (acc) begin
        i_in++;
        if (i_in < 8) is_[0] = s_in[i_in];
        else iv[0] = 1'b0;
      end
      if (ov[0]) begin
        chk("stream_data", os[0], sr(s_out[i_out]));
        if (i_out > 0)
          chk("stream_gap", 128'(cyc - last), 128'd17);
        last = cyc;
        i_out++;
      end
    end
    iv[0]   = 1'b0;
    step();
    ordy[0] = 1'b0;
    chk("stream_in_cnt", 128'(i_in), 128'd8);
    chk("stream_out_cnt", 128'(i_out), 128'd8);
    chk("stream_idle_ov", 128'(ov[0]), 128'd0);

    accept(0, fill(8'h33));
    for (int k = 0; k < 5; k++) step();
    chk("ar_busy_pre", 128'(bsy[0]), 128'd1);
    chk("ar_cnt_pre", 128'(gd[0].u_dut.cnt_q), 128'd5);
    #2 rst = 1'b1;
    #1;
    chk("ar_ov", 128'(ov[0]), 128'd0);
    chk("ar_ir", 128'(ir[0]), 128'd1);
    chk("ar_os", os[0], 128'd0);
    chk("ar_busy", 128'(bsy[0]), 128'd0);
    step();
    rst = 1'b0;
    step();
    accept(0, fill(8'h44));
    wait_out(0, 16, fill(8'h1b), "after_rst");
    release_out(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
